// File: rtl/rotate_shift_pipe.sv
// Pipelined barrel rotator/shifter: one registered stage per bit of the shift
// amount, with a global stall so every in-flight item holds under backpressure.

module rsp_stage #(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d_vld,
  input  logic [N-1:0] d_dat,
  input  logic         sh,
  input  logic [1:0]   mode,
  input  logic         sgn,
  output logic         q_vld,
  output logic [N-1:0] q_dat
);
  localparam int SH = 1 << K;

  logic [N-1:0] res;

  always_comb begin
    case (mode)
      2'b00:   res = (d_dat >> SH) | (d_dat << (N - SH));
      2'b01:   res = (d_dat << SH) | (d_dat >> (N - SH));
      2'b10:   res = d_dat >> SH;
      default: res = (d_dat >> SH) | ({N{sgn}} << (N - SH));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= 1'b0;
      q_dat <= '0;
    end else if (en) begin
      q_vld <= d_vld;
      q_dat <= sh ? res : d_dat;
    end
  end
endmodule

module rotate_shift_pipe #(
  parameter  int N = 8,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_amt,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_zero
);
  logic              stall;
  logic [S:0]        vld_pipe;
  logic [S:0][N-1:0] dat_pipe;
  logic [1:0]        mode_pipe [S];
  logic              sgn_pipe  [S];

  assign stall       = vld_pipe[S] & ~out_ready;
  assign in_ready    = ~stall;
  assign vld_pipe[0] = in_valid & in_ready;
  assign dat_pipe[0] = in_data;
  assign mode_pipe[0] = in_mode;
  // SRA fill is the operand's original sign, not whatever sits at the MSB mid-pipe
  assign sgn_pipe[0] = in_data[N-1];

  for (genvar k = 0; k < S; k++) begin : g_stg
    logic sh;

    if (k == 0) begin : g_a0
      assign sh = in_amt[0];
    end else begin : g_ad
      // amount bit k delayed k stages so it meets its own operand at stage k
      logic [k-1:0] adly;
      if (k == 1) begin : g_d1
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      adly <= '0;
          else if (!stall) adly <= in_amt[k];
        end
      end else begin : g_dn
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      adly <= '0;
          else if (!stall) adly <= {adly[k-2:0], in_amt[k]};
        end
      end
      assign sh = adly[k-1];
    end

    if (k < S - 1) begin : g_ctl
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mode_pipe[k+1] <= 2'b00;
          sgn_pipe[k+1]  <= 1'b0;
        end else if (!stall) begin
          mode_pipe[k+1] <= mode_pipe[k];
          sgn_pipe[k+1]  <= sgn_pipe[k];
        end
      end
    end

    rsp_stage #(.N(N), .K(k)) u_stg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!stall),
      .d_vld (vld_pipe[k]),
      .d_dat (dat_pipe[k]),
      .sh    (sh),
      .mode  (mode_pipe[k]),
      .sgn   (sgn_pipe[k]),
      .q_vld (vld_pipe[k+1]),
      .q_dat (dat_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[S];
  assign out_data  = dat_pipe[S];
  assign out_zero  = ~|out_data;
endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Scoreboard bench for rotate_shift_pipe at N=8 and N=32: expected results are
// queued at acceptance from a bit-index reference and popped at each transfer.

module tb_rotate_shift_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v8, r8, rdy8, ov8, oz8;
  logic [7:0]  d8, od8;
  logic [2:0]  a8;
  logic [1:0]  m8;
  logic        v32, r32, rdy32, ov32, oz32;
  logic [31:0] d32, od32;
  logic [4:0]  a32;
  logic [1:0]  m32;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb8[$];
  logic [31:0] sb32[$];

  rotate_shift_pipe #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_amt(a8), .in_mode(m8), .out_valid(ov8), .out_ready(r8),
    .out_data(od8), .out_zero(oz8));

  rotate_shift_pipe #(.N(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_amt(a32), .in_mode(m32), .out_valid(ov32), .out_ready(r32),
    .out_data(od32), .out_zero(oz32));

  // out bit i is sourced from the operand bit the single-step operation names
  function automatic logic [31:0] ref_op(input logic [31:0] d, input int amt,
                                         input logic [1:0] m, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'b00:   r[i] = d[(i + amt) % n];
        2'b01:   r[i] = d[(i - amt + n) % n];
        2'b10:   r[i] = (i + amt < n) ? d[i + amt] : 1'b0;
        default: r[i] = (i + amt < n) ? d[i + amt] : d[n-1];
      endcase
    end
    return r;
  endfunction

  task automatic step8(input bit iv, input logic [7:0] d, input logic [2:0] a,
                       input logic [1:0] m, input bit ordy, output bit acc, output bit xf,
                       output logic [7:0] got, output logic zr, output logic [7:0] exp);
    logic [31:0] t;
    @(negedge clk);
    v8 = iv; d8 = d; a8 = a; m8 = m; r8 = ordy;
    #1;
    acc = iv && rdy8; xf = ov8 && ordy; got = od8; zr = oz8; exp = 'x;
    if (xf && sb8.size() > 0) begin t = sb8.pop_front(); exp = t[7:0]; end
    if (acc) sb8.push_back(ref_op(32'(d), int'(a), m, 8));
  endtask

  task automatic step32(input bit iv, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] m, input bit ordy, output bit acc, output bit xf,
                        output logic [31:0] got, output logic zr, output logic [31:0] exp);
    @(negedge clk);
    v32 = iv; d32 = d; a32 = a; m32 = m; r32 = ordy;
    #1;
    acc = iv && rdy32; xf = ov32 && ordy; got = od32; zr = oz32; exp = 'x;
    if (xf && sb32.size() > 0) exp = sb32.pop_front();
    if (acc) sb32.push_back(ref_op(d, int'(a), m, 32));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    v8 = 0; d8 = 0; a8 = 0; m8 = 0; r8 = 0;
    v32 = 0; d32 = 0; a32 = 0; m32 = 0; r32 = 0;
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({ov8, od8, oz8, rdy8} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset8 got v=%b d=%h z=%b rdy=%b exp v=0 d=00 z=1 rdy=1", ov8, od8, oz8, rdy8);
    end
    vectors++;
    if ({ov32, od32, oz32, rdy32} !== {1'b0, 32'h0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset32 got v=%b d=%h z=%b rdy=%b exp v=0 d=0 z=1 rdy=1", ov32, od32, oz32, rdy32);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ror_sweep();
    int s = 0, nacc = 0, nres = 0, fa = -1, fx = -1, lx = -1;
    bit gap = 0, acc, xf;
    logic zr;
    logic [7:0] got, exp;
    while (nres < 8 && s < 40) begin
      step8(nacc < 8, 8'hCA, 3'(nacc), 2'b00, 1'b1, acc, xf, got, zr, exp);
      if (acc) begin if (fa < 0) fa = s; nacc++; end
      if (xf) begin
        if (fx < 0) fx = s; else if (s != lx + 1) gap = 1;
        lx = s;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL ror_sweep amt=%0d got=%b exp=%b", nres, got, exp); end
        if (nres == 0 || nres == 3) begin
          vectors++;
          if (got !== (nres == 0 ? 8'b11001010 : 8'b01011001)) begin
            miscompares++; $display("FAIL ror_fixed amt=%0d got=%b", nres, got);
          end
        end
        nres++;
      end
      s++;
    end
    vectors++;
    if (nres != 8) begin miscompares++; $display("FAIL ror_count got=%0d exp=8", nres); end
    vectors++;
    if (fx - fa != 3) begin miscompares++; $display("FAIL ror_latency got=%0d exp=3", fx - fa); end
    vectors++;
    if (gap) begin miscompares++; $display("FAIL ror_throughput got=gap exp=one per cycle"); end
  endtask

  task automatic test_modes();
    logic [7:0] din  [6] = '{8'hCA, 8'hCA, 8'hCA, 8'h4A, 8'h01, 8'h80};
    logic [2:0] ain  [6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd7};
    logic [1:0] min  [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [7:0] want [6] = '{8'h56, 8'h19, 8'hF9, 8'h09, 8'h00, 8'h01};
    int s = 0, nacc = 0, nres = 0, ix;
    bit acc, xf;
    logic zr;
    logic [7:0] got, exp;
    while (nres < 6 && s < 30) begin
      ix = (nacc < 6) ? nacc : 0;
      step8(nacc < 6, din[ix], ain[ix], min[ix], 1'b1, acc, xf, got, zr, exp);
      if (acc) nacc++;
      if (xf) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL mode_model #%0d got=%b exp=%b", nres, got, exp); end
        vectors++;
        if (got !== want[nres]) begin miscompares++; $display("FAIL mode_fixed #%0d got=%b exp=%b", nres, got, want[nres]); end
        vectors++;
        if (zr !== (want[nres] == 8'h00)) begin
          miscompares++; $display("FAIL mode_zero #%0d got=%b exp=%b", nres, zr, want[nres] == 8'h00);
        end
        nres++;
      end
      s++;
    end
    vectors++;
    if (nres != 6) begin miscompares++; $display("FAIL mode_count got=%0d exp=6", nres); end
  endtask

  task automatic test_stall();
    logic [7:0] dst [3] = '{8'h81, 8'h42, 8'h3C};
    int nacc = 0, nx = 0;
    bit gap = 0, acc, xf;
    logic zr;
    logic [7:0] got, exp, held;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      step8(1'b1, dst[nacc % 3], 3'(nacc % 3 + 1), 2'b01, 1'b0, acc, xf, got, zr, exp);
      if (acc) nacc++;
      if (i == 3) begin
        held = got;
        vectors++;
        if (got !== sb8[0][7:0]) begin miscompares++; $display("FAIL stall_head got=%h exp=%h", got, sb8[0][7:0]); end
      end
      if (i > 3) begin
        vectors++;
        if (got !== held) begin miscompares++; $display("FAIL stall_hold got=%h exp=%h", got, held); end
      end
      if (i >= 3) begin
        vectors++;
        if (rdy8 !== 1'b0 || ov8 !== 1'b1) begin
          miscompares++; $display("FAIL stall_flags got rdy=%b v=%b exp rdy=0 v=1", rdy8, ov8);
        end
      end
    end
    vectors++;
    if (nacc != 3) begin miscompares++; $display("FAIL stall_accepts got=%0d exp=3", nacc); end
    for (int i = 0; i < 6; i++) begin
      step8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, acc, xf, got, zr, exp);
      if (xf) begin
        if (i != nx) gap = 1;
        nx++;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL stall_drain #%0d got=%h exp=%h", nx, got, exp); end
      end
    end
    vectors++;
    if (nx != 3 || gap) begin miscompares++; $display("FAIL stall_drain_count got=%0d gap=%b exp=3 gap=0", nx, gap); end
  endtask

  task automatic test_random(input int n);
    int s = 0, nacc = 0, nout = 0;
    bit iv, ordy, acc, xf;
    logic zr;
    logic [31:0] d, got, exp;
    logic [7:0] g8, e8;
    logic [4:0] a;
    logic [1:0] m;
    while ((nacc < 1000 || (n == 8 ? sb8.size() : sb32.size()) > 0) && s < 10000) begin
      iv   = (nacc < 1000) && ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 3) != 0;
      d    = $urandom;
      a    = 5'($urandom_range(0, n - 1));
      m    = 2'($urandom_range(0, 3));
      if (n == 8) begin
        step8(iv, d[7:0], a[2:0], m, ordy, acc, xf, g8, zr, e8);
        got = {24'h0, g8}; exp = {24'h0, e8};
      end else begin
        step32(iv, d, a, m, ordy, acc, xf, got, zr, exp);
      end
      if (acc) nacc++;
      if (xf) begin
        nout++;
        vectors++;
        if (got !== exp || zr !== (got == 32'h0)) begin
          miscompares++; $display("FAIL random%0d #%0d got=%h z=%b exp=%h", n, nout, got, zr, exp);
        end
      end
      s++;
    end
    vectors++;
    if (nout != nacc || nacc != 1000) begin
      miscompares++; $display("FAIL random%0d_count got out=%0d acc=%0d exp 1000 each", n, nout, nacc);
    end
  endtask

  task automatic test_reset_flight();
    int stale = 0, fa = -1, lat = -1;
    bit acc, xf;
    logic zr;
    logic [7:0] got, exp;
    step8(1'b1, 8'h3C, 3'd2, 2'b01, 1'b0, acc, xf, got, zr, exp);
    step8(1'b1, 8'hA5, 3'd1, 2'b11, 1'b0, acc, xf, got, zr, exp);
    step8(1'b0, 8'h00, 3'd0, 2'b00, 1'b0, acc, xf, got, zr, exp);
    @(negedge clk);
    v8 = 1'b0; r8 = 1'b0;
    #1;
    vectors++;
    if (ov8 !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid got=%b exp=1", ov8); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ov8, od8, oz8, rdy8} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_flight got v=%b d=%h z=%b rdy=%b exp v=0 d=00 z=1 rdy=1", ov8, od8, oz8, rdy8);
    end
    sb8.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      step8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, acc, xf, got, zr, exp);
      if (xf) stale++;
    end
    vectors++;
    if (stale != 0) begin miscompares++; $display("FAIL rst_stale got=%0d exp=0", stale); end
    for (int s = 0; s < 12; s++) begin
      step8(s == 0, 8'h96, 3'd5, 2'b00, 1'b1, acc, xf, got, zr, exp);
      if (acc) fa = s;
      if (xf) begin
        lat = s - fa;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL rst_next_data got=%h exp=%h", got, exp); end
        break;
      end
    end
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL rst_next_latency got=%0d exp=3", lat); end
  endtask

  initial begin
    test_reset();
    test_ror_sweep();
    test_modes();
    test_stall();
    test_random(8);
    test_random(32);
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
